// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, instruction field positions, FSM states and flag indices for exec_unit_seq
package exec_pkg;
  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_AND     = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_XNOR    = 5'd8;
  localparam logic [4:0] OP_NAND    = 5'd9;
  localparam logic [4:0] OP_NOR     = 5'd10;
  localparam logic [4:0] OP_NOT     = 5'd11;
  localparam logic [4:0] OP_COUNT   = 5'd12;
  localparam int OPER_LSB     = 27;
  localparam int RD_LSB       = 22;
  localparam int RS1_LSB      = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RS2_LSB      = 11;
  localparam int FLAG_S = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_WB} state_t;
endpackage

// File: rtl/exec_unit_seq_mul.sv
// seq_mul: unsigned shift-add multiplier, one multiplier bit per cycle LSB first, done pulses the cycle after the last step
module seq_mul #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CW = $clog2(DATA_W);
  logic [2*DATA_W-1:0] p_q, p_d;
  logic [DATA_W-1:0] mc_q, mc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [DATA_W:0] sum;
  always_comb begin
    sum = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, mc_q} : '0);
    p_d = p_q;
    mc_d = mc_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start && !busy_q) begin
      p_d = {{DATA_W{1'b0}}, b};
      mc_d = a;
      cnt_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      p_d = {sum, p_q[DATA_W-1:1]};
      cnt_d = cnt_q + 1'b1;
      busy_d = cnt_q != CW'(DATA_W - 1);
      done_d = !busy_d;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      mc_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      p_q <= p_d;
      mc_q <= mc_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign product = p_q;
endmodule

// File: rtl/exec_unit_seq.sv
// exec_unit_seq: handshaked execute/writeback core with register file, 1-cycle ALU and iterative MUL
module exec_unit_seq
  import exec_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  localparam int REG_AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ir,
  output logic              out_valid,
  output logic [4:0]        out_rdst,
  output logic [DATA_W-1:0] out_data,
  output logic              out_illegal,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam int M = DATA_W - 1;
  state_t state_q, state_d;
  logic [4:0] op_q, op_d, rd_q, rd_d;
  logic im_q, im_d, ill_q, ill_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, sgpr_q, sgpr_d, out_data_q, out_data_d;
  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] gpr_d [NUM_REGS];
  logic [3:0] flags_q, flags_d;
  logic out_valid_q, out_valid_d, out_illegal_q, out_illegal_d;
  logic [4:0] out_rdst_q, out_rdst_d;
  logic [4:0] acc_op, acc_rd, acc_rs1, acc_rs2;
  logic acc_im, use_s1, use_s2, acc_ill, mul_start, mul_busy, mul_done;
  logic [2*DATA_W-1:0] mul_p;
  logic [DATA_W:0] sum, diff;
  logic [DATA_W-1:0] src, alu_res;
  logic alu_v, alu_c;
  assign acc_op  = in_ir[OPER_LSB +: 5];
  assign acc_rd  = in_ir[RD_LSB +: 5];
  assign acc_rs1 = in_ir[RS1_LSB +: 5];
  assign acc_rs2 = in_ir[RS2_LSB +: 5];
  assign acc_im  = in_ir[IMM_MODE_BIT];
  // Only register fields the opcode actually reads can make it illegal
  assign use_s1  = acc_op != OP_MOVSGPR && !((acc_op == OP_MOV || acc_op == OP_NOT) && acc_im);
  assign use_s2  = !acc_im && (acc_op inside {[OP_ADD:OP_NOR]});
  assign acc_ill = acc_op >= OP_COUNT || {1'b0, acc_rd} >= NR ||
                   (use_s1 && {1'b0, acc_rs1} >= NR) || (use_s2 && {1'b0, acc_rs2} >= NR);
  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    diff = {1'b0, a_q} - {1'b0, b_q};
    src = im_q ? b_q : a_q;
    alu_res = '0;
    alu_v = 1'b0;
    alu_c = 1'b0;
    case (op_q)
      OP_MOVSGPR: alu_res = sgpr_q;
      OP_MOV:     alu_res = src;
      OP_ADD: begin
        alu_res = sum[M:0];
        alu_c = sum[DATA_W];
        alu_v = (a_q[M] == b_q[M]) && (sum[M] != a_q[M]);
      end
      OP_SUB: begin
        alu_res = diff[M:0];
        alu_c = diff[DATA_W];
        alu_v = (a_q[M] != b_q[M]) && (diff[M] != a_q[M]);
      end
      OP_OR:      alu_res = a_q | b_q;
      OP_AND:     alu_res = a_q & b_q;
      OP_XOR:     alu_res = a_q ^ b_q;
      OP_XNOR:    alu_res = ~(a_q ^ b_q);
      OP_NAND:    alu_res = ~(a_q & b_q);
      OP_NOR:     alu_res = ~(a_q | b_q);
      OP_NOT:     alu_res = ~src;
      default:    alu_res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rd_d = rd_q;
    im_d = im_q;
    ill_d = ill_q;
    a_d = a_q;
    b_d = b_q;
    gpr_d = gpr_q;
    sgpr_d = sgpr_q;
    flags_d = flags_q;
    out_valid_d = 1'b0;
    out_illegal_d = 1'b0;
    out_rdst_d = out_rdst_q;
    out_data_d = out_data_q;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d = acc_op;
        rd_d = acc_rd;
        im_d = acc_im;
        ill_d = acc_ill;
        a_d = gpr_q[in_ir[RS1_LSB +: REG_AW]];
        b_d = acc_im ? DATA_W'(in_ir[15:0]) : gpr_q[in_ir[RS2_LSB +: REG_AW]];
        mul_start = acc_op == OP_MUL && !acc_ill;
        state_d = mul_start ? S_MUL : S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        out_valid_d = 1'b1;
        out_illegal_d = ill_q;
        out_rdst_d = rd_q;
        if (!ill_q) begin
          gpr_d[rd_q[REG_AW-1:0]] = alu_res;
          out_data_d = alu_res;
          flags_d[FLAG_S] = alu_res[M];
          flags_d[FLAG_Z] = alu_res == '0;
          flags_d[FLAG_V] = alu_v;
          flags_d[FLAG_C] = alu_c;
        end
      end
      S_MUL: if (mul_done && !mul_busy) state_d = S_WB;
      S_WB: begin
        state_d = S_IDLE;
        out_valid_d = 1'b1;
        out_rdst_d = rd_q;
        out_data_d = mul_p[M:0];
        gpr_d[rd_q[REG_AW-1:0]] = mul_p[M:0];
        sgpr_d = mul_p[2*DATA_W-1:DATA_W];
        flags_d = {mul_p[2*DATA_W-1], mul_p == '0, 2'b00};
      end
      default: state_d = S_IDLE;
    endcase
  end
  seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk(clk), .rst_n(rst_n), .start(mul_start), .a(a_d), .b(b_d),
    .busy(mul_busy), .done(mul_done), .product(mul_p)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
      rd_q <= '0;
      im_q <= 1'b0;
      ill_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      gpr_q <= '{default: '0};
      sgpr_q <= '0;
      flags_q <= '0;
      out_valid_q <= 1'b0;
      out_illegal_q <= 1'b0;
      out_rdst_q <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_q <= rd_d;
      im_q <= im_d;
      ill_q <= ill_d;
      a_q <= a_d;
      b_q <= b_d;
      gpr_q <= gpr_d;
      sgpr_q <= sgpr_d;
      flags_q <= flags_d;
      out_valid_q <= out_valid_d;
      out_illegal_q <= out_illegal_d;
      out_rdst_q <= out_rdst_d;
      out_data_q <= out_data_d;
    end
  end
  assign in_ready = state_q == S_IDLE;
  assign out_valid = out_valid_q;
  assign out_illegal = out_illegal_q;
  assign out_rdst = out_rdst_q;
  assign out_data = out_data_q;
  assign flags = flags_q;
  assign sgpr = sgpr_q;
  assign dbg_data = gpr_q[dbg_addr];
endmodule

// File: tb/tb_exec_unit_seq.sv
// tb_exec_unit_seq: table-driven scoreboard bench for exec_unit_seq (DATA_W=16, NUM_REGS=8)
module tb_exec_unit_seq;
  import exec_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic in_ready, out_valid, out_illegal;
  logic [31:0] in_ir = '0;
  logic [4:0] out_rdst;
  logic [15:0] out_data, sgpr, dbg_data;
  logic [3:0] flags;
  logic [2:0] dbg_addr = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] ir; logic [4:0] rd; logic [15:0] data; logic [3:0] flags;
    logic ill; logic [15:0] sgpr; int lat; bit noise;
  } vec_t;
  typedef struct {logic [4:0] rd; logic [15:0] data; logic [3:0] flags; logic ill; logic [15:0] sgpr;} exp_t;
  exp_t sb[$];
  vec_t v[$];
  always #5 clk = ~clk;
  exec_unit_seq #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .out_valid(out_valid), .out_rdst(out_rdst), .out_data(out_data), .out_illegal(out_illegal),
    .flags(flags), .sgpr(sgpr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic im, input logic [15:0] imm);
    return {op, rd, rs1, im, imm};
  endfunction
  function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return mk(op, rd, rs1, 1'b0, {rs2, 11'd0});
  endfunction
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected completion rdst=%0d data=%h", out_rdst, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_rdst", 32'(out_rdst), 32'(e.rd));
        chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        chk("flags", 32'(flags), 32'(e.flags));
        chk("sgpr", 32'(sgpr), 32'(e.sgpr));
        if (!e.ill) chk("out_data", 32'(out_data), 32'(e.data));
      end
    end
  end
  task automatic run(input vec_t t);
    int n = 0;
    @(negedge clk);
    chk("in_ready idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_ir = t.ir;
    @(posedge clk);
    sb.push_back('{t.rd, t.data, t.flags, t.ill, t.sgpr});
    #1 in_valid = 1'b0;
    chk("in_ready busy", 32'(in_ready), 32'd0);
    do begin
      @(posedge clk);
      #1 n++;
      if (t.noise) begin
        in_valid = n >= 3 && n <= 6;
        in_ir = mk(OP_MOV, 5'd3, 5'd0, 1'b1, 16'hAAAA);
      end
    end while (!out_valid && n < 40);
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(t.lat));
    @(posedge clk);
    #1 chk("pulse width", 32'(out_valid), 32'd0);
  endtask
  task automatic rd_reg(input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1 chk($sformatf("gpr%0d", a), 32'(dbg_data), 32'(exp));
  endtask
  initial begin
    v.push_back('{mk(OP_MOV, 2, 0, 1, 16'h0002), 2, 16'h0002, 4'b0000, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_ADD, 0, 2, 1, 16'h0004), 0, 16'h0006, 4'b0000, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 0, 0, 1, 16'h8000), 0, 16'h8000, 4'b1000, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 1, 0, 1, 16'h8002), 1, 16'h8002, 4'b1000, 0, 16'h0000, 1, 0});
    v.push_back('{rr(OP_ADD, 2, 0, 1),           2, 16'h0002, 4'b0011, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 1, 0, 1, 16'h0001), 1, 16'h0001, 4'b0000, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 0, 0, 1, 16'h0002), 0, 16'h0002, 4'b0000, 0, 16'h0000, 1, 0});
    v.push_back('{rr(OP_SUB, 3, 1, 0),           3, 16'hFFFF, 4'b1001, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 5, 0, 1, 16'h1234), 5, 16'h1234, 4'b0000, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 6, 0, 1, 16'h0100), 6, 16'h0100, 4'b0000, 0, 16'h0000, 1, 0});
    v.push_back('{rr(OP_MUL, 4, 5, 6),           4, 16'h3400, 4'b0000, 0, 16'h0012, 18, 1});
    v.push_back('{mk(OP_MOVSGPR, 7, 0, 0, 0),    7, 16'h0012, 4'b0000, 0, 16'h0012, 1, 0});
    v.push_back('{mk(OP_MOV, 5, 0, 1, 16'hFFFF), 5, 16'hFFFF, 4'b1000, 0, 16'h0012, 1, 0});
    v.push_back('{rr(OP_MUL, 4, 5, 5),           4, 16'h0001, 4'b1000, 0, 16'hFFFE, 18, 0});
    v.push_back('{mk(OP_MUL, 4, 5, 1, 16'h0000), 4, 16'h0000, 4'b0100, 0, 16'h0000, 18, 0});
    v.push_back('{mk(5'd13, 3, 0, 1, 16'h0001),  3, 16'h0000, 4'b0100, 1, 16'h0000, 1, 0});
    v.push_back('{mk(OP_ADD, 15, 0, 1, 16'h0001), 15, 16'h0000, 4'b0100, 1, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 1, 9, 1, 16'h0005), 1, 16'h0005, 4'b0000, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_MOV, 2, 0, 1, 16'h0000), 2, 16'h0000, 4'b0100, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_NOT, 6, 0, 1, 16'h00FF), 6, 16'hFF00, 4'b1000, 0, 16'h0000, 1, 0});
    v.push_back('{mk(OP_XOR, 6, 6, 1, 16'h0F0F), 6, 16'hF00F, 4'b1000, 0, 16'h0000, 1, 0});
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst sgpr", 32'(sgpr), 32'd0);
    rd_reg(3'd0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (v[i]) run(v[i]);
    rd_reg(3'd0, 16'h0002);
    rd_reg(3'd1, 16'h0005);
    rd_reg(3'd2, 16'h0000);
    rd_reg(3'd3, 16'hFFFF);
    rd_reg(3'd4, 16'h0000);
    rd_reg(3'd5, 16'hFFFF);
    rd_reg(3'd6, 16'hF00F);
    rd_reg(3'd7, 16'h0012);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    @(negedge clk);
    in_valid = 1'b1;
    in_ir = rr(OP_MUL, 4, 5, 5);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort out_illegal", 32'(out_illegal), 32'd0);
    chk("abort out_rdst", 32'(out_rdst), 32'd0);
    chk("abort out_data", 32'(out_data), 32'd0);
    chk("abort flags", 32'(flags), 32'd0);
    chk("abort sgpr", 32'(sgpr), 32'd0);
    for (int i = 0; i < 8; i++) rd_reg(3'(i), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("abort in_ready", 32'(in_ready), 32'd1);
    repeat (25) @(posedge clk);
    #1 chk("abort no write", 32'(dbg_data), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
